// File: rtl/vga_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_controller
// Brief    : Avalon-MM VGA timing generator drawing a background plus one
//            square sprite, with registers committed at the start of vblank.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_controller #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FRONT  = 32,
  parameter int H_SYNC   = 192,
  parameter int H_BACK   = 96,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int SPR_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk
);

  localparam logic [10:0] H_LAST    = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [10:0] SPR_EXT   = 11'(SPR_SIZE);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] ctrl;
  } bank_t;

  localparam bank_t BANK_RST = '{r: 8'h00, g: 8'h00, b: 8'h80,
                                 x: 10'd312, y: 9'd232, ctrl: 2'b01};

  logic [1:0]  rst_sync_q;
  logic        rst_n;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [15:0] frame_q, frame_d;
  bank_t       pend_q, pend_d, act_q, act_d;
  logic        irq_pend_q, irq_pend_d;
  logic [15:0] readdata_q, readdata_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, vclk_q, vclk_d;

  logic        h_wrap, v_wrap, commit, wr_en, rd_en;
  logic        active, hit, irq_set, irq_clr;
  logic [10:0] px_ext, py_ext, sx_ext, sy_ext;

  // Reset asserts asynchronously and is released on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    frame_d  = frame_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
      if (v_wrap) frame_d = frame_q + 16'd1;
    end

    commit = (hcount_q == 11'd0) && (vcount_q == V_ACT_END);
    wr_en  = chipselect && write;
    rd_en  = chipselect && read;

    // The commit copies the pre-write pending bank; a same-cycle write waits a frame.
    act_d  = commit ? pend_q : act_q;
    pend_d = pend_q;
    if (wr_en) begin
      case (address)
        3'd0: begin
          pend_d.r = writedata[15:8];
          pend_d.g = writedata[7:0];
        end
        3'd1: pend_d.b    = writedata[7:0];
        3'd2: pend_d.x    = writedata[9:0];
        3'd3: pend_d.y    = writedata[8:0];
        3'd4: pend_d.ctrl = writedata[1:0];
        default: ;
      endcase
    end

    // Enable is taken from the value being committed, so irq rises on the commit itself.
    irq_set    = commit && pend_q.ctrl[1];
    irq_clr    = wr_en && (address == 3'd5) && writedata[15];
    irq_pend_d = irq_set || (irq_pend_q && !irq_clr);

    readdata_d = 16'h0000;
    if (rd_en) begin
      case (address)
        3'd0: readdata_d = {pend_q.r, pend_q.g};
        3'd1: readdata_d = {8'h00, pend_q.b};
        3'd2: readdata_d = {6'd0, pend_q.x};
        3'd3: readdata_d = {7'd0, pend_q.y};
        3'd4: readdata_d = {14'd0, pend_q.ctrl};
        3'd5: readdata_d = {irq_pend_q, (vcount_q >= V_ACT_END), 4'b0000, vcount_q};
        3'd6: readdata_d = frame_q;
        default: readdata_d = 16'h0000;
      endcase
    end

    active = (hcount_q < H_ACT_END) && (vcount_q < V_ACT_END);
    px_ext = {1'b0, hcount_q[10:1]};
    py_ext = {1'b0, vcount_q};
    sx_ext = {1'b0, act_q.x};
    sy_ext = {2'b00, act_q.y};
    hit    = (px_ext >= sx_ext) && (px_ext < sx_ext + SPR_EXT) &&
             (py_ext >= sy_ext) && (py_ext < sy_ext + SPR_EXT);

    rgb_d = 24'h000000;
    if (active && act_q.ctrl[0]) rgb_d = hit ? 24'hFFFFFF : {act_q.r, act_q.g, act_q.b};
    hs_d    = !((hcount_q >= HS_START) && (hcount_q < HS_END));
    vs_d    = !((vcount_q >= VS_START) && (vcount_q < VS_END));
    blank_d = active;
    vclk_d  = hcount_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q   <= 11'd0;
      vcount_q   <= 10'd0;
      frame_q    <= 16'd0;
      pend_q     <= BANK_RST;
      act_q      <= BANK_RST;
      irq_pend_q <= 1'b0;
      readdata_q <= 16'h0000;
      rgb_q      <= 24'h000000;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_q    <= 1'b0;
      vclk_q     <= 1'b0;
    end else begin
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      frame_q    <= frame_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      irq_pend_q <= irq_pend_d;
      readdata_q <= readdata_d;
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      blank_q    <= blank_d;
      vclk_q     <= vclk_d;
    end
  end

  assign readdata    = readdata_q;
  assign irq         = irq_pend_q && act_q.ctrl[1];
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = vclk_q;

endmodule
`default_nettype wire

// File: doc/vga_frame_controller.md
Name: vga_frame_controller

Overview:
- Avalon-MM slave that sequences the VGA output datapath (vga_r/g/b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk) exported from soc_system.
- Generates 640x480@60 timing from the 50 MHz fabric clock, with 2 clk cycles per pixel.
- Draws a background colour plus one square sprite.
- Holds software-written registers in a pending bank and commits them to the active bank only at the start of vertical blanking, so frames never tear.
- Raises a per-frame interrupt.

Parameters:
H_ACTIVE, 1280, active clk cycles per line (2 per pixel)
H_FRONT, 32, horizontal front porch in clk cycles
H_SYNC, 192, horizontal sync width in clk cycles
H_BACK, 96, horizontal back porch in clk cycles (line total 1600)
V_ACTIVE, 480, active lines
V_FRONT, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BACK, 33, vertical back porch in lines (frame total 525)
SPR_SIZE, 16, sprite edge length in pixels

Ports:
clk  in  1  fabric clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
chipselect  in  1  Avalon slave select
write  in  1  write strobe
read  in  1  read strobe
address  in  3  register index
writedata  in  16  write data
readdata  out  16  read data, registered, 1-cycle latency
irq  out  1  frame interrupt, level-high
vga_r, vga_g, vga_b  out  8 each  pixel colour
vga_hs, vga_vs  out  1 each  sync outputs, active-low
vga_blank_n  out  1  high during active video
vga_sync_n  out  1  tied to 0
vga_clk  out  1  pixel clock, equal to hcount[0]

Behaviour:
- Clock and reset: one clock domain. reset_n asserts asynchronously and releases synchronously in the design's standard way.
- Counters:
  - hcount is 11 bits, runs 0..1599, then wraps.
  - vcount is 10 bits, increments when hcount wraps, runs 0..524, then wraps.
  - Frame counter is 16 bits, increments when vcount wraps, and wraps at 0xFFFF.
- Timing, registered from the counters with 1 cycle of latency (all VGA outputs are aligned to the same cycle):
  - active = hcount < 1280 and vcount < 480.
  - vga_hs is low for hcount in [1312,1504).
  - vga_vs is low for vcount in [490,492).
  - vga_blank_n = active.
- Register map. Writes take effect when chipselect and write are both high. Reads return data on the cycle after chipselect and read; readdata is 0 for unmapped addresses.
  - 0 BG_RG: [15:8] red, [7:0] green.
  - 1 BG_B: [7:0] blue.
  - 2 SPR_X: [9:0] sprite x.
  - 3 SPR_Y: [8:0] sprite y.
  - 4 CTRL: bit0 display enable, bit1 irq enable.
  - 5 STATUS. Read: {irq_pend, vblank, 4'b0, vcount}, where vblank = (vcount >= 480). Write: bit15=1 clears irq_pend.
  - 6 FRAME: frame counter, read-only.
  - Addresses 0-4 read back the pending value.
- Pending/active banks:
  - Addresses 0-4 write the pending bank.
  - Commit cycle = hcount==0 and vcount==480. On that cycle active <= pending.
  - A write landing on the commit cycle updates pending only. The commit takes the pre-write value, and the write appears at the next commit.
- Pixel generation:
  - px = hcount[10:1], py = vcount.
  - Sprite hit = px >= SPR_X and px < SPR_X+SPR_SIZE and py >= SPR_Y and py < SPR_Y+SPR_SIZE, computed at 11 bits. The sprite is clipped at the right/bottom edges, never wrapped.
  - Colour: active and enable and hit gives FFFFFF; active and enable gives the background colour; otherwise 000000.
  - Disabling the display does not stop sync generation.
- Interrupt:
  - irq_pend sets on the commit cycle when active CTRL bit1 = 1.
  - If a set and a clear occur in the same cycle, the set wins.
  - irq = irq_pend AND active CTRL bit1.
- Reset values:
  - hcount, vcount and frame counter = 0; readdata = 0; irq_pend = 0; irq = 0.
  - vga_r/g/b = 0, vga_hs = 1, vga_vs = 1, vga_blank_n = 0, vga_sync_n = 0.
  - Both banks: BG = 000080, SPR_X = 312, SPR_Y = 232, CTRL = 01.
- Reset mid-frame: counters restart at 0 and all outputs return to their reset values immediately. Pending writes are lost.

Test Plan:
- Release reset, run 2 frames: hs low 192 cycles every 1600; vs low exactly 3200 cycles every 840000; blank_n high 1280 cycles per active line; FRAME reads 2.
- After reset, sample pixel (0,0): rgb 000080. Sample pixel (312,232) and (327,247): FFFFFF. Sample (328,232): 000080.
- Write SPR_X=100 at vcount=100: sprite stays at x=312 for the rest of that frame; the next frame shows FFFFFF at px=100..115.
- Write BG_B=0x55 exactly on the commit cycle (hcount=0, vcount=480): the following frame still shows blue 80; the frame after shows 55.
- Write CTRL=3, wait for commit: irq rises at hcount=0, vcount=480. Write STATUS 0x8000: irq falls next cycle. Clear issued on a commit cycle: irq stays 1.
- Write SPR_X=630, SPR_Y=470: sprite clipped, px 630..639 white, px 0..5 of the same lines background. Write CTRL=0: rgb 000000 while hs/vs continue unchanged.
